// File: rtl/branch_predictor_pkg.sv
// Branch predictor shared definitions.
// Table sizing, counter encodings and in-flight record layout.
package branch_predictor_pkg;

  localparam int BP_INDEX_BITS = 6;
  localparam int BP_TAG_BITS   = 8;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [31:0] BP_DELAY_SLOT_SKIP = 32'd8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_rec_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter.
// Pure next-state logic; no wrap at either end.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] nxt_o
);

  // step toward taken or not-taken, clamping at the ends
  always_comb begin
    nxt_o = cur_i;
    unique case (cur_i)
      CNT_SNT: nxt_o = taken_i ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt_o = taken_i ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt_o = taken_i ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt_o = taken_i ? CNT_ST  : CNT_WT;
      default: nxt_o = cur_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit BHT plus tagged BTB.
// Checks each prediction against ID's resolution and redirects IF.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int TAG_BITS   = BP_TAG_BITS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Lookup_PC,
  input  logic        Lookup_Valid,
  input  logic        STALL,
  output logic        Pred_Taken,
  output logic [31:0] Pred_Target,
  input  logic        Resolve_Valid,
  input  logic [31:0] Resolve_PC,
  input  logic        isBranch,
  input  logic        isTaken,
  input  logic [31:0] Alt_PC_IN,
  output logic        Mispredict,
  output logic [31:0] Correct_PC,
  output logic [31:0] Branch_Count,
  output logic [31:0] Miss_Count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TLO     = INDEX_BITS + 2;
  localparam int THI     = INDEX_BITS + TAG_BITS + 1;

  logic [1:0]          bht_q       [ENTRIES];
  logic                btb_valid_q [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q   [ENTRIES];
  logic [31:0]         btb_tgt_q   [ENTRIES];

  bp_rec_t rec_q;

  logic        mis_q;
  logic [31:0] cpc_q;
  logic [31:0] bcnt_q;
  logic [31:0] mcnt_q;

  logic [INDEX_BITS-1:0] lidx;
  logic [TAG_BITS-1:0]   ltag;
  logic                  lhit;
  logic [INDEX_BITS-1:0] ridx;
  logic [TAG_BITS-1:0]   rtag;
  logic [1:0]            bht_nxt;

  logic        upd;
  logic        act_tk;
  logic        rec_match;
  logic        prd_tk;
  logic        miss;

  assign lidx = Lookup_PC[INDEX_BITS+1:2];
  assign ltag = Lookup_PC[THI:TLO];
  assign ridx = Resolve_PC[INDEX_BITS+1:2];
  assign rtag = Resolve_PC[THI:TLO];

  // tables are read before any same-cycle write lands
  always_comb begin
    lhit        = btb_valid_q[lidx] && (btb_tag_q[lidx] == ltag);
    Pred_Taken  = Lookup_Valid && lhit && bht_q[lidx][1];
    Pred_Target = Pred_Taken ? btb_tgt_q[lidx] : 32'd0;
  end

  // without a matching record the fetch assumed fall-through
  always_comb begin
    upd       = !STALL && Resolve_Valid;
    act_tk    = isBranch && isTaken;
    rec_match = rec_q.valid && (rec_q.pc == Resolve_PC);
    prd_tk    = rec_match && rec_q.taken;
    miss      = (prd_tk != act_tk)
             || (prd_tk && act_tk && (rec_q.target != Alt_PC_IN));
  end

  bp_sat_counter u_cnt (
    .cur_i   (bht_q[ridx]),
    .taken_i (isTaken),
    .nxt_o   (bht_nxt)
  );

  // train direction counters and target buffer on resolved branches
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i]       <= CNT_WNT;
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
    end else if (upd && isBranch) begin
      bht_q[ridx] <= bht_nxt;
      if (isTaken) begin
        btb_valid_q[ridx] <= 1'b1;
        btb_tag_q[ridx]   <= rtag;
        btb_tgt_q[ridx]   <= Alt_PC_IN;
      end
    end
  end

  // carry this fetch's prediction to ID; a redirect squashes it
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rec_q <= '0;
    end else if (!STALL) begin
      rec_q.valid  <= Lookup_Valid && !mis_q;
      rec_q.pc     <= Lookup_PC;
      rec_q.taken  <= Pred_Taken;
      rec_q.target <= Pred_Target;
    end
  end

  // redirect pulse, correct fetch PC and performance counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mis_q  <= 1'b0;
      cpc_q  <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (upd) begin
      mis_q <= miss;
      cpc_q <= act_tk ? Alt_PC_IN : Resolve_PC + BP_DELAY_SLOT_SKIP;
      if (isBranch) bcnt_q <= bcnt_q + 32'd1;
      if (miss)     mcnt_q <= mcnt_q + 32'd1;
    end else begin
      mis_q <= 1'b0;
    end
  end

  assign Mispredict   = mis_q;
  assign Correct_PC   = cpc_q;
  assign Branch_Count = bcnt_q;
  assign Miss_Count   = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor.
// Registered results are queued on drive and compared after the edge.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Lookup_PC;
  logic        Lookup_Valid;
  logic        STALL;
  logic        Pred_Taken;
  logic [31:0] Pred_Target;
  logic        Resolve_Valid;
  logic [31:0] Resolve_PC;
  logic        isBranch;
  logic        isTaken;
  logic [31:0] Alt_PC_IN;
  logic        Mispredict;
  logic [31:0] Correct_PC;
  logic [31:0] Branch_Count;
  logic [31:0] Miss_Count;

  branch_predictor dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .Lookup_PC     (Lookup_PC),
    .Lookup_Valid  (Lookup_Valid),
    .STALL         (STALL),
    .Pred_Taken    (Pred_Taken),
    .Pred_Target   (Pred_Target),
    .Resolve_Valid (Resolve_Valid),
    .Resolve_PC    (Resolve_PC),
    .isBranch      (isBranch),
    .isTaken       (isTaken),
    .Alt_PC_IN     (Alt_PC_IN),
    .Mispredict    (Mispredict),
    .Correct_PC    (Correct_PC),
    .Branch_Count  (Branch_Count),
    .Miss_Count    (Miss_Count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  logic        m_mis;
  logic [31:0] m_cpc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    sb_t e;
    sbq.push_back('{0, {31'd0, m_mis}, {tag, ".mispredict"}});
    sbq.push_back('{1, m_cpc, {tag, ".correct_pc"}});
    sbq.push_back('{2, m_bc, {tag, ".branch_count"}});
    sbq.push_back('{3, m_mc, {tag, ".miss_count"}});
    @(posedge CLK);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0:       chk(e.tag, {31'd0, Mispredict}, e.exp);
        1:       chk(e.tag, Correct_PC, e.exp);
        2:       chk(e.tag, Branch_Count, e.exp);
        default: chk(e.tag, Miss_Count, e.exp);
      endcase
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc,
                       input logic pt, input logic [31:0] tgt);
    Lookup_Valid  = 1'b1;
    Lookup_PC     = pc;
    Resolve_Valid = 1'b0;
    STALL         = 1'b0;
    #1;
    chk({tag, ".pred_taken"}, {31'd0, Pred_Taken}, {31'd0, pt});
    chk({tag, ".pred_target"}, Pred_Target, tgt);
    m_mis = 1'b0;
    tick(tag);
  endtask

  task automatic idle(input string tag);
    Lookup_Valid  = 1'b0;
    Resolve_Valid = 1'b0;
    STALL         = 1'b0;
    m_mis         = 1'b0;
    tick(tag);
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic br,
                           input logic tk, input logic [31:0] alt);
    Lookup_Valid  = 1'b0;
    Resolve_Valid = 1'b1;
    Resolve_PC    = pc;
    isBranch      = br;
    isTaken       = tk;
    Alt_PC_IN     = alt;
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc,
                         input logic br, input logic tk,
                         input logic [31:0] alt, input logic miss);
    drive_res(pc, br, tk, alt);
    STALL = 1'b0;
    m_mis = miss;
    m_cpc = (br && tk) ? alt : pc + 32'd8;
    if (br)   m_bc = m_bc + 32'd1;
    if (miss) m_mc = m_mc + 32'd1;
    tick(tag);
  endtask

  task automatic stall_res(input string tag, input logic [31:0] pc,
                           input logic br, input logic tk,
                           input logic [31:0] alt);
    drive_res(pc, br, tk, alt);
    STALL = 1'b1;
    m_mis = 1'b0;
    tick(tag);
  endtask

  initial begin
    RESET         = 1'b0;
    Lookup_PC     = '0;
    Lookup_Valid  = 1'b0;
    STALL         = 1'b0;
    Resolve_Valid = 1'b0;
    Resolve_PC    = '0;
    isBranch      = 1'b0;
    isTaken       = 1'b0;
    Alt_PC_IN     = '0;
    m_mis         = 1'b0;
    m_cpc         = '0;
    m_bc          = '0;
    m_mc          = '0;

    #12;
    chk("rst.mispredict", {31'd0, Mispredict}, 32'd0);
    chk("rst.correct_pc", Correct_PC, 32'd0);
    chk("rst.branch_count", Branch_Count, 32'd0);
    chk("rst.miss_count", Miss_Count, 32'd0);
    RESET = 1'b1;

    // cold lookup
    fetch("t1.cold", 32'h0040_0000, 1'b0, 32'd0);

    // train taken twice
    fetch("t2.f1", 32'h0040_0010, 1'b0, 32'd0);
    resolve("t2.r1", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b1);
    idle("t2.i1");
    fetch("t2.f2", 32'h0040_0010, 1'b1, 32'h0040_0100);
    resolve("t2.r2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0);
    fetch("t2.f3", 32'h0040_0010, 1'b1, 32'h0040_0100);

    // direction miss: 11 -> 10 still predicts taken
    resolve("t3.r", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 1'b1);
    idle("t3.i");
    fetch("t3.f", 32'h0040_0010, 1'b1, 32'h0040_0100);

    // target miss retargets the BTB
    resolve("t4.r", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200, 1'b1);
    idle("t4.i");
    fetch("t4.f", 32'h0040_0010, 1'b1, 32'h0040_0200);

    // stall holds everything, resolve counted once afterwards
    for (int i = 0; i < 3; i++)
      stall_res("t5.stall", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    resolve("t5.r", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200, 1'b0);

    // non-branch: fall-through, no count
    fetch("t5.nb.f", 32'h0040_0020, 1'b0, 32'd0);
    resolve("t5.nb.r", 32'h0040_0020, 1'b0, 1'b0, 32'd0, 1'b0);

    // same index, different tag (PC[15:8] differs)
    fetch("t6.alias", 32'h0040_1010, 1'b0, 32'd0);

    // leave a live redirect, then reset mid-cycle
    fetch("t6.f", 32'h0040_0010, 1'b1, 32'h0040_0200);
    resolve("t6.r", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0200, 1'b1);
    Lookup_Valid  = 1'b1;
    Lookup_PC     = 32'h0040_0010;
    Resolve_Valid = 1'b0;
    #1;
    chk("t6.pre.pred_taken", {31'd0, Pred_Taken}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("t6.rst.pred_taken", {31'd0, Pred_Taken}, 32'd0);
    chk("t6.rst.pred_target", Pred_Target, 32'd0);
    chk("t6.rst.mispredict", {31'd0, Mispredict}, 32'd0);
    chk("t6.rst.correct_pc", Correct_PC, 32'd0);
    chk("t6.rst.branch_count", Branch_Count, 32'd0);
    chk("t6.rst.miss_count", Miss_Count, 32'd0);
    chk("sb.empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
